c1541_sd_arb: RTL and testbench
===============================

# c1541_sd_arb

Multi-drive SD arbiter and media-sense block for the 1541 subsystem. Sits in the `clk_sys` domain between up to four `c1541_track`-style drive channels and the single host SD block interface. It round-robin arbitrates their sector read/write requests and steers ack, buffer-write strobes and write data to the granted drive. It also generates each drive's write-protect sense, including the disk-change toggle window the 1541 DOS uses to detect a swapped disk.

## Interface
Parameters:
- `NDRIVES`, default 4: number of drive channels, legal range 1..4.
- `CH_TIMEOUT`, default 15000000: length of the disk-change sense window, in `clk_sys` cycles.

Ports:
- `clk_sys` in 1: single clock; everything is in this domain.
- `reset_n` in 1: reset, asynchronous and active-low.
- `drv_lba` in NDRIVES*32: per-drive sector LBA; drive i occupies bits [32i+31:32i].
- `drv_rd` in NDRIVES: per-drive read request, level, held until its ack.
- `drv_wr` in NDRIVES: per-drive write request, level, held until its ack.
- `drv_buff_din` in NDRIVES*8: per-drive write data toward SD; drive i occupies bits [8i+7:8i].
- `drv_ack` out NDRIVES: host ack, steered to the granted drive.
- `drv_buff_wr` out NDRIVES: host buffer-write strobe, steered to the granted drive.
- `disk_change` in NDRIVES: image-mount strobe; a rising edge is an event.
- `disk_readonly` in NDRIVES: readonly flag for the image, sampled on the `disk_change` rise.
- `drv_wps_n` out NDRIVES: write-protect sense to each drive, active-low.
- `sd_lba` out 32: LBA presented to the host.
- `sd_rd` out 1: host read request.
- `sd_wr` out 1: host write request.
- `sd_ack` in 1: host transfer ack.
- `sd_buff_wr` in 1: host buffer-write strobe.
- `sd_buff_din` out 8: write data to the host.
- `grant` out 2: index of the granted drive.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- The arbiter FSM has four states: IDLE, REQ, XFER, DONE.
- IDLE:
  - pending = `drv_rd | drv_wr`.
  - If pending is nonzero, the winner is the first set bit strictly after `last_grant`, searching modulo NDRIVES.
  - On a win: latch `grant`, `sd_lba` and the direction; write wins if the same drive raises `drv_rd` and `drv_wr` together. Go to REQ.
- REQ:
  - `sd_rd` or `sd_wr` is high according to the latched direction.
  - When `sd_ack` is seen high: drop `sd_rd`/`sd_wr`, update `last_grant`, go to XFER.
- XFER: when `sd_ack` goes low, go to DONE.
- DONE: go to IDLE once the granted drive's `drv_rd` and `drv_wr` are both low. This prevents re-granting a stale request.
- Steering:
  - `drv_ack[grant] = sd_ack` in REQ and XFER; all other `drv_ack` bits are 0.
  - `drv_buff_wr[grant] = sd_buff_wr` in XFER; all other bits are 0.
  - `sd_buff_din = drv_buff_din[grant]` at all times.
- Requests are never aborted. `disk_change` and LBA changes during REQ or XFER do not affect the transfer in flight; the LBA is latched.
- Change sense, per drive:
  - On a `disk_change` rising edge: counter ← CH_TIMEOUT and ro ← `disk_readonly`.
  - While the counter is > 0 it decrements and chg = 1; otherwise chg = 0.
  - A new edge while counting reloads the counter.
  - `drv_wps_n = ~ro ^ chg`, registered.
- Reset while not IDLE: the FSM returns to IDLE and `sd_rd`/`sd_wr` drop immediately. The host must tolerate a dropped request.

## Timing
- Reset values:
  - `sd_rd`, `sd_wr`, `busy`, `drv_ack`, `drv_buff_wr` = 0.
  - `sd_lba` = 0, `grant` = 0, `last_grant` = NDRIVES-1.
  - Counters = 0, ro = 0, so `drv_wps_n` = all 1.
- A request high at edge n (in IDLE) gives `sd_rd`/`sd_wr` high after edge n+1.
- `sd_ack` high at edge m drops `sd_rd`/`sd_wr` after edge m+1.
- `drv_ack`, `drv_buff_wr` and `sd_buff_din` are combinational from registered `grant` and state, with zero latency relative to `sd_ack`/`sd_buff_wr`.
- Minimum turnaround between back-to-back grants is DONE plus IDLE: 2 cycles after `sd_ack` falls, provided the drive has released its request.
- A change window lasts exactly CH_TIMEOUT cycles of chg = 1. `drv_wps_n` lags chg by 1 cycle.
- Counter width is `$clog2(CH_TIMEOUT+1)`.

## Configuration
- Macro: `C1541_SD_CHSENSE_EN`.
- Defined: change-sense counters are built as described; `drv_wps_n` toggles for the window.
- Undefined: no counters are built. `drv_wps_n = ~ro`, where ro is latched on the `disk_change` rise. The arbiter is unchanged.

## Structure
- Package `c1541_sd_pkg` holds:
  - the FSM state enum (IDLE, REQ, XFER, DONE);
  - `C1541_LBA_W` = 32;
  - `C1541_MAX_DRIVES` = 4.
- Sub-module `c1541_chsense`: one drive's edge detect, ro latch, counter and `wps_n`. Instantiated NDRIVES times in a generate loop.

## Test plan
- Single read: drive 1 raises `drv_rd` with LBA 0x120. Required:
  - `sd_lba` = 0x120 and `sd_rd` high 1 cycle later;
  - the ack pulse and 512 `sd_buff_wr` strobes appear only on `drv_ack[1]` and `drv_buff_wr[1]`;
  - FSM back in IDLE once `drv_rd` drops.
- Round-robin: drives 0, 2 and 3 request simultaneously with `last_grant` = 0. Required grant order: 2, 3, 0.
- Write steering: drive 3 raises `drv_wr` with `drv_buff_din[31:24]` = 0xA5. Required: `sd_wr` high and `sd_buff_din` = 0xA5 during XFER; `drv_rd`/`drv_ack` of the other drives stay 0.
- Change sense with NDRIVES=2, CH_TIMEOUT=10, macro defined: `disk_change[0]` rises with readonly = 1. Required: `drv_wps_n[0]` is 1 for 10 cycles, then 0; `drv_wps_n[1]` stays 1.
- Reset mid-transfer: assert `reset_n` = 0 during XFER. Required: `sd_rd`, `busy`, `drv_ack` and `drv_buff_wr` go to 0 asynchronously; after release, a new request is granted normally.

Source files
------------

// File: rtl/c1541_sd_pkg.sv
// Shared types and constants for the 1541 multi-drive SD arbiter.
package c1541_sd_pkg;

  localparam int C1541_LBA_W      = 32;
  localparam int C1541_MAX_DRIVES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/c1541_chsense.sv
// One drive's write-protect sense: mount edge detect, readonly latch and,
// with C1541_SD_CHSENSE_EN defined, the disk-change toggle window.
module c1541_chsense #(
  parameter int CH_TIMEOUT = 15000000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic disk_change,
  input  logic disk_readonly,
  output logic wps_n
);

  if (CH_TIMEOUT < 1) begin : g_bad_cfg
    $error("c1541_chsense: CH_TIMEOUT must be at least 1");
  end

  logic change_prev;
  logic ro;
  logic rise;

  assign rise = disk_change & ~change_prev;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      change_prev <= 1'b0;
      ro          <= 1'b0;
    end else begin
      change_prev <= disk_change;
      if (rise) ro <= disk_readonly;
    end
  end

`ifdef C1541_SD_CHSENSE_EN
  localparam int CW = $clog2(CH_TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          chg;
  logic          wps_q;

  assign chg = (cnt != '0);

  // A fresh mount edge restarts the window even if one is still running.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      wps_q <= 1'b1;
    end else begin
      if (rise)     cnt <= CW'(CH_TIMEOUT);
      else if (chg) cnt <= cnt - 1'b1;
      wps_q <= ~ro ^ chg;
    end
  end

  assign wps_n = wps_q;
`else
  assign wps_n = ~ro;
`endif

endmodule

// File: rtl/c1541_sd_arb.sv
// Round-robin arbiter steering up to four drive channels onto one host SD
// block port, plus per-drive write-protect sense (C1541_SD_CHSENSE_EN).
module c1541_sd_arb
  import c1541_sd_pkg::*;
#(
  parameter int NDRIVES    = 4,
  parameter int CH_TIMEOUT = 15000000
) (
  input  logic                           clk_sys,
  input  logic                           reset_n,
  input  logic [NDRIVES*C1541_LBA_W-1:0] drv_lba,
  input  logic [NDRIVES-1:0]             drv_rd,
  input  logic [NDRIVES-1:0]             drv_wr,
  input  logic [NDRIVES*8-1:0]           drv_buff_din,
  output logic [NDRIVES-1:0]             drv_ack,
  output logic [NDRIVES-1:0]             drv_buff_wr,
  input  logic [NDRIVES-1:0]             disk_change,
  input  logic [NDRIVES-1:0]             disk_readonly,
  output logic [NDRIVES-1:0]             drv_wps_n,
  output logic [C1541_LBA_W-1:0]         sd_lba,
  output logic                           sd_rd,
  output logic                           sd_wr,
  input  logic                           sd_ack,
  input  logic                           sd_buff_wr,
  output logic [7:0]                     sd_buff_din,
  output logic [1:0]                     grant,
  output logic                           busy
);

  if (NDRIVES < 1 || NDRIVES > C1541_MAX_DRIVES) begin : g_bad_cfg
    $error("c1541_sd_arb: NDRIVES must be in 1..4");
  end

  arb_state_t state, state_nxt;

  logic [NDRIVES-1:0][C1541_LBA_W-1:0] lba_arr;
  logic [NDRIVES-1:0][7:0]             din_arr;
  logic [NDRIVES-1:0]                  pending;
  logic [1:0]                          grant_q, last_grant;
  logic [1:0]                          win_idx;
  logic                                win_found;
  logic                                dir_wr;
  logic [C1541_LBA_W-1:0]              lba_q;
  logic                                sd_rd_q, sd_wr_q;

  assign lba_arr = drv_lba;
  assign din_arr = drv_buff_din;
  assign pending = drv_rd | drv_wr;

  // First pending drive strictly after last_grant, wrapping modulo NDRIVES.
  always_comb begin
    int         idx;
    logic [1:0] cand;
    idx       = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NDRIVES; k++) begin
      idx  = (int'(last_grant) + k) % NDRIVES;
      cand = 2'(idx);
      if (!win_found && pending[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    drv_ack     = '0;
    drv_buff_wr = '0;
    case (state)
      IDLE: if (win_found) state_nxt = REQ;
      REQ: begin
        drv_ack[grant_q] = sd_ack;
        if (sd_ack) state_nxt = XFER;
      end
      XFER: begin
        drv_ack[grant_q]     = sd_ack;
        drv_buff_wr[grant_q] = sd_buff_wr;
        if (!sd_ack) state_nxt = DONE;
      end
      // Hold until the served drive lets go so its old level is not re-granted.
      DONE: if (!drv_rd[grant_q] && !drv_wr[grant_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= 2'(NDRIVES - 1);
      lba_q      <= '0;
      dir_wr     <= 1'b0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Host request is the REQ state delayed one cycle.
      sd_rd_q <= (state == REQ) && !dir_wr;
      sd_wr_q <= (state == REQ) && dir_wr;
      if (state == IDLE && win_found) begin
        grant_q <= win_idx;
        lba_q   <= lba_arr[win_idx];
        dir_wr  <= drv_wr[win_idx];
      end
      if (state == REQ && sd_ack) last_grant <= grant_q;
    end
  end

  assign sd_lba      = lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign grant       = grant_q;
  assign busy        = (state != IDLE);
  assign sd_buff_din = din_arr[grant_q];

  for (genvar i = 0; i < NDRIVES; i++) begin : g_chs
    c1541_chsense #(
      .CH_TIMEOUT(CH_TIMEOUT)
    ) u_chsense (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .disk_change  (disk_change[i]),
      .disk_readonly(disk_readonly[i]),
      .wps_n        (drv_wps_n[i])
    );
  end

endmodule

// File: tb/tb_c1541_sd_arb.sv
// Bench for c1541_sd_arb: table of single transfers, scoreboarded grants,
// plus hand sequences for round-robin, reset mid-transfer and change sense.
module tb_c1541_sd_arb;

  localparam int ND = 4;
  localparam int CH = 10;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [ND*32-1:0]  drv_lba = '0;
  logic [ND-1:0]     drv_rd = '0, drv_wr = '0;
  logic [ND*8-1:0]   drv_buff_din = '0;
  logic [ND-1:0]     drv_ack, drv_buff_wr, drv_wps_n;
  logic [ND-1:0]     disk_change = '0, disk_readonly = '0;
  logic [31:0]       sd_lba;
  logic              sd_rd, sd_wr;
  logic              sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [7:0]        sd_buff_din;
  logic [1:0]        grant;
  logic              busy;

  c1541_sd_arb #(.NDRIVES(ND), .CH_TIMEOUT(CH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .drv_lba(drv_lba), .drv_rd(drv_rd),
    .drv_wr(drv_wr), .drv_buff_din(drv_buff_din), .drv_ack(drv_ack),
    .drv_buff_wr(drv_buff_wr), .disk_change(disk_change),
    .disk_readonly(disk_readonly), .drv_wps_n(drv_wps_n), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .grant(grant), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [1:0]  g;
    logic        wr;
    logic [31:0] lba;
    logic [7:0]  din;
  } exp_t;

  typedef struct {
    int          drv;
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic [7:0]  din;
    logic        exp_wr;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_req(input int d, input logic rd, input logic wr,
                         input logic [31:0] lba, input logic [7:0] din);
    drv_lba[d*32 +: 32]     = lba;
    drv_buff_din[d*8 +: 8]  = din;
    drv_rd[d]               = rd;
    drv_wr[d]               = wr;
  endtask

  // Host model: wait for a request, score it, ack, stream nbuf strobes, drop ack.
  task automatic serve(input int nbuf, input bit release_req);
    exp_t       e;
    int         t;
    int         bad;
    logic [3:0] oh;
    t = 0;
    while (!(sd_rd | sd_wr) && t < 40) begin
      @(negedge clk_sys);
      t++;
    end
    if (!(sd_rd | sd_wr)) begin
      check("req_timeout", 64'd0, 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    e  = sb.pop_front();
    oh = 4'b0001 << e.g;
    check("grant", 64'(grant), 64'(e.g));
    check("sd_lba", 64'(sd_lba), 64'(e.lba));
    check("sd_wr", 64'(sd_wr), 64'(e.wr));
    check("sd_rd", 64'(sd_rd), 64'(!e.wr));
    sd_ack = 1'b1;
    #1 check("drv_ack_req", 64'(drv_ack), 64'(oh));
    @(negedge clk_sys);
    check("req_hold_after_ack", 64'(sd_rd | sd_wr), 64'd1);
    bad = 0;
    for (int k = 0; k < nbuf; k++) begin
      sd_buff_wr = 1'b1;
      #1 if (drv_buff_wr !== oh || sd_buff_din !== e.din || drv_ack !== oh) bad++;
      @(negedge clk_sys);
    end
    sd_buff_wr = 1'b0;
    check("buff_strobes", 64'(bad), 64'd0);
    check("req_dropped", 64'(sd_rd | sd_wr), 64'd0);
    sd_ack = 1'b0;
    #1 check("drv_ack_low", 64'(drv_ack), 64'd0);
    @(negedge clk_sys);
    if (release_req) begin
      drv_rd[e.g] = 1'b0;
      drv_wr[e.g] = 1'b0;
      @(negedge clk_sys);
      check("idle_after_release", 64'(busy), 64'd0);
    end
  endtask

  vec_t vecs[5];

  initial begin
    int   t;
    exp_t e;
    logic exp_w;

    vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_0010, 8'h3C, 1'b0};
    vecs[1] = '{3, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'hA5, 1'b1};
    vecs[2] = '{2, 1'b1, 1'b1, 32'h0000_0200, 8'h5A, 1'b1};
    vecs[3] = '{1, 1'b0, 1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1};
    vecs[4] = '{0, 1'b1, 1'b0, 32'h0000_0000, 8'h00, 1'b0};

    // Reset state
    #12;
    check("rst_sd_rd", 64'(sd_rd), 64'd0);
    check("rst_sd_wr", 64'(sd_wr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drv_ack", 64'(drv_ack), 64'd0);
    check("rst_drv_buff_wr", 64'(drv_buff_wr), 64'd0);
    check("rst_sd_lba", 64'(sd_lba), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_wps_n", 64'(drv_wps_n), 64'hF);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Single read on drive 1 with a full 512-byte sector
    set_req(1, 1'b1, 1'b0, 32'h120, 8'h77);
    sb.push_back('{2'd1, 1'b0, 32'h120, 8'h77});
    @(negedge clk_sys);
    check("sr_lba_latched", 64'(sd_lba), 64'h120);
    check("sr_rd_not_yet", 64'(sd_rd), 64'd0);
    check("sr_busy", 64'(busy), 64'd1);
    @(negedge clk_sys);
    check("sr_rd_high", 64'(sd_rd), 64'd1);
    serve(512, 1'b0);
    repeat (3) @(negedge clk_sys);
    check("sr_done_holds", 64'(busy), 64'd1);
    check("sr_no_regrant", 64'(sd_rd), 64'd0);
    drv_rd[1] = 1'b0;
    @(negedge clk_sys);
    check("sr_idle", 64'(busy), 64'd0);

    // Table of single transfers; the LBA input is scrambled after grant
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < ND; d++) set_req(d, 1'b0, 1'b0, 32'h1111_0000 + d, 8'hC0 + 8'(d));
      set_req(vecs[i].drv, vecs[i].rd, vecs[i].wr, vecs[i].lba, vecs[i].din);
      sb.push_back('{2'(vecs[i].drv), vecs[i].exp_wr, vecs[i].lba, vecs[i].din});
      @(negedge clk_sys);
      drv_lba[vecs[i].drv*32 +: 32] = ~vecs[i].lba;
      serve(4, 1'b1);
    end

    // Round-robin: last_grant is 0 here, so 0,2,3 pending -> 2,3,0
    set_req(0, 1'b1, 1'b0, 32'h0A00, 8'h10);
    set_req(2, 1'b0, 1'b1, 32'h0A02, 8'h12);
    set_req(3, 1'b1, 1'b0, 32'h0A03, 8'h13);
    sb.push_back('{2'd2, 1'b1, 32'h0A02, 8'h12});
    sb.push_back('{2'd3, 1'b0, 32'h0A03, 8'h13});
    sb.push_back('{2'd0, 1'b0, 32'h0A00, 8'h10});
    for (int i = 0; i < 3; i++) serve(3, 1'b1);
    check("rr_sb_drained", 64'(sb.size()), 64'd0);

    // Change sense on drive 0, readonly image
    disk_readonly[0] = 1'b1;
    disk_change[0]   = 1'b1;
    for (int k = 1; k <= CH + 3; k++) begin
      @(negedge clk_sys);
`ifdef C1541_SD_CHSENSE_EN
      exp_w = (k <= CH + 1);
`else
      exp_w = 1'b0;
`endif
      check($sformatf("wps0_k%0d", k), 64'(drv_wps_n[0]), 64'(exp_w));
      check("wps_others", 64'(drv_wps_n[3:1]), 64'h7);
    end
    disk_change[0] = 1'b0;

    // Reset in the middle of a transfer
    set_req(1, 1'b1, 1'b0, 32'h0B01, 8'h21);
    t = 0;
    while (!sd_rd && t < 40) begin
      @(negedge clk_sys);
      t++;
    end
    check("rm_req_seen", 64'(sd_rd), 64'd1);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    sd_buff_wr = 1'b1;
    #1 check("rm_steer", 64'(drv_buff_wr), 64'h2);
    reset_n = 1'b0;
    #1;
    check("rm_sd_rd", 64'(sd_rd), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    check("rm_drv_ack", 64'(drv_ack), 64'd0);
    check("rm_drv_buff_wr", 64'(drv_buff_wr), 64'd0);
    check("rm_wps", 64'(drv_wps_n), 64'hF);
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    drv_rd     = '0;
    drv_wr     = '0;
    sb.delete();
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    set_req(2, 1'b1, 1'b0, 32'h0C02, 8'h32);
    sb.push_back('{2'd2, 1'b0, 32'h0C02, 8'h32});
    serve(2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
